rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter and sequencer for the 4:1 byte-select mux datapath. It shares one output channel between four requesters. It picks a winner, drives the mux address, and registers the selected word. The word is then presented on a valid/ready output handshake. It sits between the four data sources and the single downstream consumer, and replaces hand-driven address sequencing of the mux.

## Interface
- W, 8, data width per requester in bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request per requester; req[i] belongs to requester i.
- data_in  input  4*W  packed words in concatenation order {d0,d1,d2,d3}. Requester i occupies data_in[(3-i)*W +: W], so d0 is in the MSBs.
- ack  output  4  one-hot, combinational; ack[i] = grant[i] & out_valid & out_ready.
- grant  output  4  one-hot registered grant; all zeros when idle.
- address  output  2  registered index of the granted requester; this is the mux select.
- out_valid  output  1  data_out holds a granted word.
- out_ready  input  1  downstream accepts the word.
- data_out  output  W  registered word of the granted requester.

## Operation
- States:
  - IDLE: out_valid=0, grant=0.
  - BUSY: out_valid=1, grant one-hot.
- Arbitration:
  - Search for the first i with req[i]=1, in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - ptr is a 2-bit priority pointer, wrapping 3 -> 0.
- IDLE -> BUSY: when any req bit is 1 at a rising edge, that same edge does all of the following:
  - grant <= onehot(winner)
  - address <= winner
  - data_out <= word of winner
  - out_valid <= 1
- BUSY hold: while out_ready=0, grant, address, data_out and out_valid stay stable. Changes on req or data_in are ignored.
- Transfer: a transfer happens on a cycle with out_valid=1 and out_ready=1. On that cycle:
  - ack[address] is 1.
  - ptr <= address+1 (mod 4) at the edge.
  - Arbitration runs in the same cycle. It uses the new pointer and masks out the requester just served.
  - If another requester is pending, go to BUSY with the new winner. This gives back-to-back transfers with no bubble.
  - Otherwise go to IDLE: out_valid <= 0, grant <= 0. address and data_out keep their last values.
- The served requester must drop req or update its data after seeing ack. Because of the mask, it cannot win again until one cycle after its ack.
- Requester contract: hold req and the data word stable until ack. A req deasserted before grant is simply not considered. req deasserted while granted does not revoke the grant.
- Fairness: with all four requesting continuously, grants rotate with period 4 cycles when out_ready=1. No requester waits more than 3 transfers.
- Reset values (mid-operation reset included, applied immediately and asynchronously):
  - state=IDLE
  - out_valid=0
  - grant=4'b0000
  - address=2'b00
  - data_out=0
  - ptr=0
  - ack=0
  - Any in-flight word is discarded with no ack.

## Timing
- Request-to-valid latency is 1 cycle. req sampled at edge k gives out_valid=1 after edge k.
- Throughput is 1 word/cycle with multiple requesters and out_ready held at 1. A single repeating requester gets 1 word per 2 cycles, because of the mask.
- ack is combinational from registered grant and out_valid plus the out_ready input. There is no combinational path from req or data_in to any output.
- out_ready may be asserted before out_valid. No transfer occurs while out_valid=0.

## Test plan
- Reset: assert rst_n=0 mid-BUSY with out_ready=0.
  - Required immediately: out_valid=0, grant=0000, address=00, data_out=0.
  - After release, req=4'b0100 -> grant requester 2 (address=10).
- Single request: data words 0,1,2,3 for d0..d3, req=4'b0010, out_ready=1.
  - Cycle after req: grant=0010, address=01, data_out=1.
  - ack[1]=1 that cycle, then IDLE.
- Rotation: all req=1, out_ready=1 held, words 0,1,2,3.
  - data_out sequence is 0,1,2,3,0,1,... on consecutive cycles, with out_valid continuously 1.
- Backpressure: req=4'b1001, out_ready=0 for 5 cycles, then 1.
  - During the stall: data_out=0 and address=00, stable. Change d0 to 8'hAA in the stall; data_out stays 0.
  - On release, transfer, then grant requester 3 the next cycle.
- Wrap and mask: ptr at 3, only requester 3 requesting, holding req high after ack.
  - Sequence: grant 3, ack, one IDLE cycle, grant 3 again.
  - ptr wraps to 0 after each transfer.
- Idle readiness: out_ready=1 with req=0 for 10 cycles -> out_valid=0, ack=0, outputs unchanged.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter and sequencer for the 4:1 byte-select mux datapath.
//   Picks one of four requesters, drives the mux select (address), registers
//   the selected word and presents it on a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester
//   data_in    packed words {d0,d1,d2,d3}; d0 in the MSBs
//   ack[3:0]   one-hot transfer acknowledge (combinational)
//   grant[3:0] registered one-hot grant, zero when idle
//   address    registered index of the granted requester (mux select)
//   out_valid  data_out holds a granted word
//   out_ready  downstream accepts the word
//   data_out   registered word of the granted requester
module rr_mux_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data_in,
  output logic [3:0]     ack,
  output logic [3:0]     grant,
  output logic [1:0]     address,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   data_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  logic [1:0]   ptr;
  logic         xfer;
  logic [1:0]   base;
  logic [3:0]   elig;
  logic         found;
  logic [1:0]   winner;
  logic [1:0]   idx;
  logic [W-1:0] words [4];

  assign xfer = out_valid & out_ready;
  assign ack  = grant & {4{xfer}};

  // On a transfer the search starts from the pointer value being written this
  // edge (address+1) and excludes the requester just served, so a repeating
  // requester sits out one cycle while others get back-to-back grants.
  always_comb begin
    base   = xfer ? address + 2'd1 : ptr;
    elig   = xfer ? (req & ~(4'b0001 << address)) : req;
    found  = 1'b0;
    winner = base;
    idx    = base;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      words[i] = data_in[(3-i)*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      address   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      if (xfer) begin
        ptr <= address + 2'd1;
      end
      // BUSY without a transfer holds everything stable.
      if (state == IDLE || xfer) begin
        if (found) begin
          state     <= BUSY;
          out_valid <= 1'b1;
          grant     <= 4'b0001 << winner;
          address   <= winner;
          data_out  <= words[winner];
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          grant     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [1:0]  address;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  data_out;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // {out_valid, grant, address, data_out, ack}
  logic [18:0] obs;
  assign obs = {out_valid, grant, address, data_out, ack};

  rr_mux_arbiter #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
    .grant(grant), .address(address), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] exp_o(input logic v, input logic [3:0] g,
      input logic [1:0] a, input logic [7:0] d, input logic [3:0] k);
    return {v, g, a, d, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    data_in = {8'd0, 8'd1, 8'd2, 8'd3};
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_o(0, 4'b0000, 2'd0, 8'd0, 4'b0000)) begin
      n_fail++; $display("FAIL reset_initial got %h want %h", obs, exp_o(0, 4'b0000, 2'd0, 8'd0, 4'b0000));
    end
    rst_n = 1'b1;
    req = 4'b0001;
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b0001, 2'd0, 8'd0, 4'b0000)) begin
      n_fail++; $display("FAIL reset_busy_before got %h want %h", obs, exp_o(1, 4'b0001, 2'd0, 8'd0, 4'b0000));
    end
    // make the pre-reset state distinguishable from reset values
    req = 4'b0000;
    out_ready = 1'b1;
    #1;
    out_ready = 1'b0;
    req = 4'b0010;
    tick();
    tick();
    out_ready = 1'b1;
    req = 4'b1000;
    tick();
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b1000, 2'd3, 8'd3, 4'b0000)) begin
      n_fail++; $display("FAIL reset_busy_mid got %h want %h", obs, exp_o(1, 4'b1000, 2'd3, 8'd3, 4'b0000));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== exp_o(0, 4'b0000, 2'd0, 8'd0, 4'b0000)) begin
      n_fail++; $display("FAIL reset_async got %h want %h", obs, exp_o(0, 4'b0000, 2'd0, 8'd0, 4'b0000));
    end
    rst_n = 1'b1;
    req = 4'b0100;
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b0100, 2'd2, 8'd2, 4'b0000)) begin
      n_fail++; $display("FAIL reset_after_grant got %h want %h", obs, exp_o(1, 4'b0100, 2'd2, 8'd2, 4'b0000));
    end
  endtask

  task automatic test_single();
    do_reset();
    data_in = {8'd0, 8'd1, 8'd2, 8'd3};
    req = 4'b0010;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b0010, 2'd1, 8'd1, 4'b0010)) begin
      n_fail++; $display("FAIL single_grant got %h want %h", obs, exp_o(1, 4'b0010, 2'd1, 8'd1, 4'b0010));
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (obs !== exp_o(0, 4'b0000, 2'd1, 8'd1, 4'b0000)) begin
      n_fail++; $display("FAIL single_idle got %h want %h", obs, exp_o(0, 4'b0000, 2'd1, 8'd1, 4'b0000));
    end
  endtask

  task automatic test_rotation();
    logic [1:0] r;
    do_reset();
    data_in = {8'd0, 8'd1, 8'd2, 8'd3};
    req = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      r = 2'(i);
      n_checks++;
      if (obs !== exp_o(1, 4'b0001 << r, r, 8'(r), 4'b0001 << r)) begin
        n_fail++; $display("FAIL rotation_%0d got %h want %h", i, obs, exp_o(1, 4'b0001 << r, r, 8'(r), 4'b0001 << r));
      end
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (obs !== exp_o(0, 4'b0000, 2'd3, 8'd3, 4'b0000)) begin
      n_fail++; $display("FAIL rotation_idle got %h want %h", obs, exp_o(0, 4'b0000, 2'd3, 8'd3, 4'b0000));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    data_in = {8'd0, 8'd1, 8'd2, 8'd3};
    req = 4'b1001;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) data_in[31:24] = 8'hAA;
      n_checks++;
      if (obs !== exp_o(1, 4'b0001, 2'd0, 8'd0, 4'b0000)) begin
        n_fail++; $display("FAIL stall_%0d got %h want %h", i, obs, exp_o(1, 4'b0001, 2'd0, 8'd0, 4'b0000));
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (obs !== exp_o(1, 4'b0001, 2'd0, 8'd0, 4'b0001)) begin
      n_fail++; $display("FAIL stall_release got %h want %h", obs, exp_o(1, 4'b0001, 2'd0, 8'd0, 4'b0001));
    end
    tick();
    req = 4'b1000;
    n_checks++;
    if (obs !== exp_o(1, 4'b1000, 2'd3, 8'd3, 4'b1000)) begin
      n_fail++; $display("FAIL stall_next got %h want %h", obs, exp_o(1, 4'b1000, 2'd3, 8'd3, 4'b1000));
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (obs !== exp_o(0, 4'b0000, 2'd3, 8'd3, 4'b0000)) begin
      n_fail++; $display("FAIL stall_idle got %h want %h", obs, exp_o(0, 4'b0000, 2'd3, 8'd3, 4'b0000));
    end
  endtask

  task automatic test_wrap_mask();
    do_reset();
    data_in = {8'h10, 8'h11, 8'h12, 8'h13};
    out_ready = 1'b1;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    // ptr now 3
    req = 4'b1000;
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b1000, 2'd3, 8'h13, 4'b1000)) begin
      n_fail++; $display("FAIL wrap_grant1 got %h want %h", obs, exp_o(1, 4'b1000, 2'd3, 8'h13, 4'b1000));
    end
    tick();
    n_checks++;
    if (obs !== exp_o(0, 4'b0000, 2'd3, 8'h13, 4'b0000)) begin
      n_fail++; $display("FAIL wrap_masked got %h want %h", obs, exp_o(0, 4'b0000, 2'd3, 8'h13, 4'b0000));
    end
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b1000, 2'd3, 8'h13, 4'b1000)) begin
      n_fail++; $display("FAIL wrap_grant2 got %h want %h", obs, exp_o(1, 4'b1000, 2'd3, 8'h13, 4'b1000));
    end
    tick();
    // ptr wrapped to 0: with 0 and 3 both requesting, 0 must win
    req = 4'b1001;
    tick();
    n_checks++;
    if (obs !== exp_o(1, 4'b0001, 2'd0, 8'h10, 4'b0001)) begin
      n_fail++; $display("FAIL wrap_ptr0 got %h want %h", obs, exp_o(1, 4'b0001, 2'd0, 8'h10, 4'b0001));
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_idle_ready();
    out_ready = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_o(0, 4'b0000, 2'd0, 8'h10, 4'b0000)) begin
        n_fail++; $display("FAIL idle_%0d got %h want %h", i, obs, exp_o(0, 4'b0000, 2'd0, 8'h10, 4'b0000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap_mask();
    test_idle_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
